// File: rtl/cla_pkg.sv
// Shared constants and operation encoding for the pipelined carry-lookahead adder.
package cla_pkg;

  localparam int CLA_WIDTH = 16;
  localparam int CLA_GROUP = 4;

  typedef enum logic {
    CLA_ADD = 1'b0,
    CLA_SUB = 1'b1
  } cla_op_e;

endpackage

// File: rtl/cla_group.sv
// One GROUP-bit carry-lookahead slice: bit sums, carry out, and group generate/propagate.
module cla_group #(
  parameter int GROUP = 4
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             cin,
  output logic [GROUP-1:0] sum,
  output logic             cout,
  output logic             g,
  output logic             p
);

  logic [GROUP-1:0] gen;
  logic [GROUP-1:0] prop;
  logic [GROUP-1:0] pre_g;
  logic [GROUP-1:0] pre_p;
  logic [GROUP:0]   carry;

  // pre_g/pre_p are prefix generate/propagate over bits [i:0], so every
  // carry is a two-level function of cin rather than a ripple chain.
  always_comb begin
    gen      = a & b;
    prop     = a ^ b;
    pre_g    = '0;
    pre_p    = '0;
    carry    = '0;
    pre_g[0] = gen[0];
    pre_p[0] = prop[0];
    for (int i = 1; i < GROUP; i++) begin
      pre_g[i] = gen[i] | (prop[i] & pre_g[i-1]);
      pre_p[i] = prop[i] & pre_p[i-1];
    end
    carry[0] = cin;
    for (int i = 0; i < GROUP; i++) begin
      carry[i+1] = pre_g[i] | (pre_p[i] & cin);
    end
    sum = prop ^ carry[GROUP-1:0];
  end

  assign cout = carry[GROUP];
  assign g    = pre_g[GROUP-1];
  assign p    = pre_p[GROUP-1];

endmodule

// File: rtl/pipelined_cla_adder.sv
// Add/subtract pipeline, one lookahead group resolved per stage, valid/ready at both ends.
// Define CLA_OVF_EN to add the signed-overflow output ovf.
module pipelined_cla_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = CLA_WIDTH,
  parameter int GROUP = CLA_GROUP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum,
  output logic             cout
`ifdef CLA_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int GS = (GROUP < 1) ? 1 : GROUP;
  localparam int NG = (WIDTH / GS < 1) ? 1 : WIDTH / GS;

  if (GROUP < 1 || WIDTH < 1 || (WIDTH % GS) != 0) begin : g_bad_cfg
    $error("pipelined_cla_adder: WIDTH must be a positive multiple of GROUP >= 1");
  end

  // valid/ready: a transfer happens on a rising edge where valid and ready are
  // both high; in_ready sees out_ready only through the stage advance chain.
  cla_op_e          op;
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;

  assign op    = cla_op_e'(sub);
  assign b_eff = (op == CLA_SUB) ? ~b : b;
  assign c_eff = (op == CLA_SUB) ? ~cin : cin;

  logic [NG-1:0]    vld_q;
  logic [NG-1:0]    c_q;
  logic [WIDTH-1:0] a_q  [NG];
  logic [WIDTH-1:0] b_q  [NG];
  logic [WIDTH-1:0] s_q  [NG];
  logic [WIDTH-1:0] a_in [NG];
  logic [WIDTH-1:0] b_in [NG];
  logic [WIDTH-1:0] s_in [NG];
  logic [WIDTH-1:0] s_nx [NG];
  logic [GS-1:0]    grp_sum [NG];
  logic [NG-1:0]    c_in;
  logic [NG-1:0]    v_in;
  logic [NG-1:0]    c_nx;
  logic [NG-1:0]    g_grp;
  logic [NG-1:0]    p_grp;
  logic [NG-1:0]    adv;
  logic [NG-1:0]    load;

  always_comb begin
    a_in[0] = a;
    b_in[0] = b_eff;
    s_in[0] = '0;
    c_in    = '0;
    v_in    = '0;
    c_in[0] = c_eff;
    v_in[0] = in_valid;
    for (int k = 1; k < NG; k++) begin
      a_in[k] = a_q[k-1];
      b_in[k] = b_q[k-1];
      s_in[k] = s_q[k-1];
      c_in[k] = c_q[k-1];
      v_in[k] = vld_q[k-1];
    end
  end

  // A stage advances when it holds data and the next stage will have room.
  always_comb begin
    adv       = '0;
    adv[NG-1] = vld_q[NG-1] & out_ready;
    for (int k = NG - 2; k >= 0; k--) begin
      adv[k] = vld_q[k] & (~vld_q[k+1] | adv[k+1]);
    end
    load = ~vld_q | adv;
  end

  for (genvar k = 0; k < NG; k++) begin : g_stage
    cla_group #(.GROUP(GS)) u_group (
      .a    (a_in[k][k*GS +: GS]),
      .b    (b_in[k][k*GS +: GS]),
      .cin  (c_in[k]),
      .sum  (grp_sum[k]),
      .cout (c_nx[k]),
      .g    (g_grp[k]),
      .p    (p_grp[k])
    );
  end

  always_comb begin
    for (int k = 0; k < NG; k++) begin
      s_nx[k]              = s_in[k];
      s_nx[k][k*GS +: GS]  = grp_sum[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      c_q   <= '0;
      for (int k = 0; k < NG; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NG; k++) begin
        if (load[k]) begin
          vld_q[k] <= v_in[k];
          if (v_in[k]) begin
            a_q[k] <= a_in[k];
            b_q[k] <= b_in[k];
            s_q[k] <= s_nx[k];
            c_q[k] <= c_nx[k];
          end
        end
      end
    end
  end

  assign in_ready  = load[0];
  assign out_valid = vld_q[NG-1];
  assign sum       = {c_q[NG-1], s_q[NG-1]};
  assign cout      = c_q[NG-1];

`ifdef CLA_OVF_EN
  // Operand sign bits ride down the pipe, so overflow is formed at the output.
  assign ovf = (a_q[NG-1][WIDTH-1] == b_q[NG-1][WIDTH-1]) &
               (s_q[NG-1][WIDTH-1] != a_q[NG-1][WIDTH-1]);
`endif

  logic unused_bits;
  assign unused_bits = ^{g_grp, p_grp, a_q[NG-1], b_q[NG-1]};

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Directed and model-checked bench for pipelined_cla_adder (16/4 and 8/2 instances).
module tb_pipelined_cla_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout;
  logic [15:0] a, b;
  logic [16:0] sum;
`ifdef CLA_OVF_EN
  logic        ovf;
`endif

  logic        in_valid_s, in_ready_s, cin_s, sub_s, out_valid_s, out_ready_s, cout_s;
  logic [7:0]  a_s, b_s;
  logic [8:0]  sum_s;
`ifdef CLA_OVF_EN
  logic        ovf_s;
`endif

  int n_cmp = 0;
  int n_err = 0;

  pipelined_cla_adder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout)
`ifdef CLA_OVF_EN
    , .ovf(ovf)
`endif
  );

  pipelined_cla_adder #(.WIDTH(8), .GROUP(2)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid_s), .in_ready(in_ready_s),
    .a(a_s), .b(b_s), .cin(cin_s), .sub(sub_s),
    .out_valid(out_valid_s), .out_ready(out_ready_s), .sum(sum_s), .cout(cout_s)
`ifdef CLA_OVF_EN
    , .ovf(ovf_s)
`endif
  );

  function automatic logic [16:0] ref16(logic [15:0] x, logic [15:0] y, logic ci, logic s);
    logic [15:0] yy;
    logic        cc;
    yy = s ? ~y : y;
    cc = s ? ~ci : ci;
    return {1'b0, x} + {1'b0, yy} + {16'b0, cc};
  endfunction

  function automatic logic [8:0] ref8(logic [7:0] x, logic [7:0] y, logic ci, logic s);
    logic [7:0] yy;
    logic       cc;
    yy = s ? ~y : y;
    cc = s ? ~ci : ci;
    return {1'b0, x} + {1'b0, yy} + {8'b0, cc};
  endfunction

  // Driver: offer one operation to the 16-bit instance, then wait for its result.
  task automatic run_single(input logic [15:0] xa, input logic [15:0] xb,
                            input logic xc, input logic xs, output int lat);
    @(posedge clk); #1;
    in_valid = 1'b1; a = xa; b = xb; cin = xc; sub = xs;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    in_valid_s = 1'b0; a_s = '0; b_s = '0; cin_s = 1'b0; sub_s = 1'b0; out_ready_s = 1'b1;
    #3;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_cmp++; if (sum !== 17'h0) begin n_err++; $display("FAIL reset_sum: got %h expected 00000", sum); end
    n_cmp++; if (cout !== 1'b0) begin n_err++; $display("FAIL reset_cout: got %b expected 0", cout); end
    n_cmp++; if (out_valid_s !== 1'b0) begin n_err++; $display("FAIL reset_out_valid_s: got %b expected 0", out_valid_s); end
`ifdef CLA_OVF_EN
    n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_cmp++; if (in_ready_s !== 1'b1) begin n_err++; $display("FAIL reset_in_ready_s: got %b expected 1", in_ready_s); end
  endtask

  logic [15:0] va [6];
  logic [15:0] vb [6];
  logic        vc [6];
  logic        vs [6];
  logic [16:0] ve [6];

  task automatic test_add_sub;
    int lat;
    va[0] = 16'hFFFF; vb[0] = 16'h0001; vc[0] = 1'b0; vs[0] = 1'b0; ve[0] = 17'h10000;
    va[1] = 16'h0005; vb[1] = 16'h0007; vc[1] = 1'b0; vs[1] = 1'b1; ve[1] = 17'h0FFFE;
    va[2] = 16'h0007; vb[2] = 16'h0005; vc[2] = 1'b1; vs[2] = 1'b1; ve[2] = 17'h10001;
    va[3] = 16'h1234; vb[3] = 16'h4321; vc[3] = 1'b1; vs[3] = 1'b0; ve[3] = 17'h05556;
    va[4] = 16'h0000; vb[4] = 16'h0000; vc[4] = 1'b0; vs[4] = 1'b1; ve[4] = 17'h10000;
    va[5] = 16'h8000; vb[5] = 16'h8000; vc[5] = 1'b1; vs[5] = 1'b0; ve[5] = 17'h10001;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      run_single(va[i], vb[i], vc[i], vs[i], lat);
      n_cmp++; if (lat != 4) begin n_err++; $display("FAIL latency[%0d]: got %0d expected 4", i, lat); end
      n_cmp++; if (sum !== ve[i]) begin n_err++; $display("FAIL sum[%0d]: got %h expected %h", i, sum, ve[i]); end
      n_cmp++; if (cout !== ve[i][16]) begin n_err++; $display("FAIL cout[%0d]: got %b expected %b", i, cout, ve[i][16]); end
      @(posedge clk); #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL drained[%0d]: got %b expected 0", i, out_valid); end
    end
  endtask

`ifdef CLA_OVF_EN
  task automatic test_ovf;
    int lat;
    out_ready = 1'b1;
    run_single(16'h7FFF, 16'h0001, 1'b0, 1'b0, lat);
    n_cmp++; if (sum !== 17'h08000) begin n_err++; $display("FAIL ovf_add_sum: got %h expected 08000", sum); end
    n_cmp++; if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf_add: got %b expected 1", ovf); end
    run_single(16'h0001, 16'h0001, 1'b0, 1'b0, lat);
    n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL ovf_small: got %b expected 0", ovf); end
    run_single(16'h8000, 16'h0001, 1'b0, 1'b1, lat);
    n_cmp++; if (sum[15:0] !== 16'h7FFF) begin n_err++; $display("FAIL ovf_sub_sum: got %h expected 7fff", sum[15:0]); end
    n_cmp++; if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf_sub: got %b expected 1", ovf); end
    @(posedge clk); #1;
  endtask
`endif

  task automatic test_back_to_back;
    logic [16:0] exp_q[$];
    int idx, got, cyc, inlow;
    logic [15:0] xa, xb;
    idx = 0; got = 0; cyc = 0; inlow = 0;
    @(posedge clk); #1;
    while (got < 10 && cyc < 100) begin
      out_ready = !(cyc >= 2 && cyc <= 6);
      xa = 16'(idx * 16'h1357 + 16'h0F0F);
      xb = 16'(16'hF00F ^ (idx * 16'h0101));
      if (idx < 10) begin
        in_valid = 1'b1; a = xa; b = xb; sub = idx[0]; cin = idx[1];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      n_cmp++;
      if (in_ready !== ((exp_q.size() < 4) || out_ready)) begin
        n_err++; $display("FAIL b2b_in_ready[c%0d]: got %b with %0d held", cyc, in_ready, exp_q.size());
      end
      if (!in_ready) inlow++;
      if (out_valid) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL b2b_spurious[c%0d]: got %h expected no result", cyc, sum);
        end else if (sum !== exp_q[0]) begin
          n_err++; $display("FAIL b2b_sum[c%0d]: got %h expected %h", cyc, sum, exp_q[0]);
        end
        if (out_ready && exp_q.size() != 0) begin
          void'(exp_q.pop_front());
          got++;
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref16(xa, xb, idx[1], idx[0]));
        idx++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_cmp++; if (got != 10) begin n_err++; $display("FAIL b2b_count: got %0d expected 10", got); end
    n_cmp++; if (inlow != 3) begin n_err++; $display("FAIL b2b_stall_cycles: got %0d expected 3", inlow); end
  endtask

  task automatic test_reset_midflight;
    int w, stale;
    out_ready = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = 16'(16'h0100 + i); b = 16'h0011; cin = 1'b0; sub = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    w = 0;
    while (!out_valid && w < 10) begin
      @(posedge clk); #1;
      w++;
    end
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL midrst_pre_valid: got %b expected 1", out_valid); end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid: got %b expected 0", out_valid); end
    n_cmp++; if (sum !== 17'h0) begin n_err++; $display("FAIL midrst_sum: got %h expected 00000", sum); end
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    stale = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid) stale++;
    end
    n_cmp++; if (stale != 0) begin n_err++; $display("FAIL midrst_stale: got %0d expected 0", stale); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL midrst_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_random_small;
    logic [8:0] exp_q[$];
    int ts_q[$];
    int sent, got, cyc;
    logic hold;
    sent = 0; got = 0; cyc = 0; hold = 1'b0;
    @(posedge clk); #1;
    while (got < 1000 && cyc < 20000) begin
      out_ready_s = (got < 50) ? 1'b1 : ($urandom_range(0, 9) < 7);
      if (!hold) begin
        if (sent < 1000 && $urandom_range(0, 9) < 8) begin
          in_valid_s = 1'b1;
          a_s = 8'($urandom_range(0, 255)); b_s = 8'($urandom_range(0, 255));
          cin_s = 1'($urandom_range(0, 1)); sub_s = 1'($urandom_range(0, 1));
          hold = 1'b1;
        end else begin
          in_valid_s = 1'b0;
        end
      end
      #1;
      if (out_valid_s && out_ready_s) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL rnd_spurious[c%0d]: got %h expected no result", cyc, sum_s);
        end else begin
          if (sum_s !== exp_q[0] || cout_s !== exp_q[0][8]) begin
            n_err++; $display("FAIL rnd_sum[%0d]: got %h/%b expected %h", got, sum_s, cout_s, exp_q[0]);
          end
          if (got < 50) begin
            n_cmp++;
            if (cyc - ts_q[0] != 4) begin
              n_err++; $display("FAIL rnd_latency[%0d]: got %0d expected 4", got, cyc - ts_q[0]);
            end
          end
          void'(exp_q.pop_front());
          void'(ts_q.pop_front());
        end
        got++;
      end
      if (in_valid_s && in_ready_s) begin
        exp_q.push_back(ref8(a_s, b_s, cin_s, sub_s));
        ts_q.push_back(cyc);
        sent++;
        hold = 1'b0;
      end
      @(posedge clk); #1;
      if (!hold) in_valid_s = 1'b0;
      cyc++;
    end
    in_valid_s = 1'b0; out_ready_s = 1'b1;
    n_cmp++; if (got != 1000) begin n_err++; $display("FAIL rnd_count: got %0d expected 1000", got); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_add_sub();
`ifdef CLA_OVF_EN
    test_ovf();
`endif
    test_back_to_back();
    test_reset_midflight();
    test_random_small();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
